fxp_requant_pipe: RTL and testbench

- Multi-channel fixed-point format converter between blocks that use different Q formats, e.g. a conv-layer 16-bit activation stream feeding a 32-bit accumulator domain, or the accumulator narrowed back to activations.
- Converts C signed channels per beat from Q(IN_W-IN_F).IN_F to Q(OUT_W-OUT_F).OUT_F.
- Sign-extends, rounds, saturates, and flags clipping.
- Two-stage valid/ready pipeline with a saturation-event counter for on-chip overflow monitoring.

---
 rtl/fxp_requant_pipe.sv | 106 ++++++++++
 tb/tb_fxp_requant_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_requant_pipe.sv
// Converts C signed channels from Q(IN_W-IN_F).IN_F to Q(OUT_W-OUT_F).OUT_F with rounding, saturation and a clip counter.
// Latency 2, 1 beat/cycle; in_ready = !out_valid || out_ready stalls both stages. Define FXP_ROUND_EN for round-half-up when narrowing.
module fxp_requant_pipe #(
  parameter int C     = 4,
  parameter int IN_W  = 16,
  parameter int IN_F  = 12,
  parameter int OUT_W = 32,
  parameter int OUT_F = 24,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C*IN_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C*OUT_W-1:0] out_data,
  output logic [C-1:0]       out_sat,
  output logic [CNT_W-1:0]   sat_count,
  input  logic               clr_sat
);
  localparam int SH  = OUT_F - IN_F;
  localparam int ASH = (SH < 0) ? -SH : SH;
  localparam int WW  = IN_W + ASH + OUT_W;
  localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic               w_en;
  logic               w_cnt_inc;
  logic [C*WW-1:0]    w_aln;
  logic [C*OUT_W-1:0] w_sat_dat;
  logic [C-1:0]       w_sat;

  logic               r_s1_vld;
  logic [C*WW-1:0]    r_s1_dat;
  logic               r_out_vld;
  logic [C*OUT_W-1:0] r_out_dat;
  logic [C-1:0]       r_out_sat;
  logic [CNT_W-1:0]   r_sat_cnt;

  assign w_en      = !r_out_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_cnt;

  for (genvar k = 0; k < C; k++) begin : g_ch
    logic signed [IN_W-1:0] w_in;
    logic signed [WW-1:0]   w_ext;
    logic signed [WW-1:0]   w_s1;
    logic                   w_hi;
    logic                   w_lo;

    assign w_in  = in_data[k*IN_W +: IN_W];
    assign w_ext = {{(WW-IN_W){w_in[IN_W-1]}}, w_in};

    if (SH >= 0) begin : g_up
      assign w_aln[k*WW +: WW] = w_ext <<< ASH;
    end else begin : g_dn
`ifdef FXP_ROUND_EN
      // Half-LSB bias fits in the working width, so the add cannot wrap.
      localparam logic signed [WW-1:0] HALF = WW'(1) << (ASH - 1);
      logic signed [WW-1:0] w_rnd;
      assign w_rnd = w_ext + HALF;
      assign w_aln[k*WW +: WW] = w_rnd >>> ASH;
`else
      assign w_aln[k*WW +: WW] = w_ext >>> ASH;
`endif
    end

    assign w_s1     = r_s1_dat[k*WW +: WW];
    assign w_hi     = w_s1 > MAXV;
    assign w_lo     = w_s1 < MINV;
    assign w_sat[k] = w_hi || w_lo;
    assign w_sat_dat[k*OUT_W +: OUT_W] = w_hi ? MAXV[OUT_W-1:0] :
                                         (w_lo ? MINV[OUT_W-1:0] : w_s1[OUT_W-1:0]);
  end

  assign w_cnt_inc = r_out_vld && out_ready && (|r_out_sat) && (r_sat_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_dat  <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_sat <= '0;
      r_sat_cnt <= '0;
    end else begin
      if (w_en) begin
        r_s1_vld  <= in_valid;
        r_s1_dat  <= w_aln;
        r_out_vld <= r_s1_vld;
        r_out_dat <= w_sat_dat;
        r_out_sat <= w_sat;
      end
      if (clr_sat) begin
        r_sat_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fxp_requant_pipe.sv
// Bench for fxp_requant_pipe: widening (default) and narrowing (CNT_W=2) instances against an arithmetic reference model.
module tb_fxp_requant_pipe;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   lat_on;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // widening instance (defaults)
  logic         va, ra, ora, oa_v, clr_a;
  logic [63:0]  da;
  logic [127:0] oa_dat;
  logic [3:0]   sa;
  logic [15:0]  ca;

  // narrowing instance
  logic         vn, rn, orn, on_v, clr_n;
  logic [127:0] dn;
  logic [63:0]  odn;
  logic [3:0]   sn;
  logic [1:0]   cn;

  fxp_requant_pipe u_wide (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_data(da),
    .out_valid(oa_v), .out_ready(ora), .out_data(oa_dat), .out_sat(sa),
    .sat_count(ca), .clr_sat(clr_a)
  );

  fxp_requant_pipe #(.C(4), .IN_W(32), .IN_F(24), .OUT_W(16), .OUT_F(12), .CNT_W(2)) u_nar (
    .clk(clk), .rst(rst), .in_valid(vn), .in_ready(rn), .in_data(dn),
    .out_valid(on_v), .out_ready(orn), .out_data(odn), .out_sat(sn),
    .sat_count(cn), .clr_sat(clr_n)
  );

  typedef struct {
    logic [127:0] dat;
    logic [3:0]   sat;
    int           acc;
    bit           lat;
    bit           seen;
  } exp_t;

  exp_t qa[$];
  exp_t qn[$];
  int   cnt_a = 0;
  int   cnt_n = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: real-valued rescale by 2^(OUT_F-IN_F), floor or round-half-up, then clamp.
  function automatic void model(input logic [127:0] din, input int iw, input int inf,
                                input int ow, input int of,
                                output logic [127:0] dout, output logic [3:0] sat);
    longint x, y, d, lim;
    int sh;
    dout = '0;
    sat  = '0;
    sh   = of - inf;
    for (int k = 0; k < 4; k++) begin
      x = longint'(din >> (k * iw));
      x = x & ((longint'(1) << iw) - 1);
      if (x >= (longint'(1) << (iw - 1))) x = x - (longint'(1) << iw);
      if (sh >= 0) begin
        y = x * (longint'(1) << sh);
      end else begin
        d = longint'(1) << (-sh);
`ifdef FXP_ROUND_EN
        x = x + d / 2;
`endif
        y = floor_div(x, d);
      end
      lim = longint'(1) << (ow - 1);
      if (y > lim - 1) begin
        y = lim - 1;
        sat[k] = 1'b1;
      end else if (y < -lim) begin
        y = -lim;
        sat[k] = 1'b1;
      end
      dout = dout | (128'(y & ((longint'(1) << ow) - 1)) << (k * ow));
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (oa_v) begin
      if (qa.size() == 0) chk("a_spurious_valid", oa_v, 0);
      else begin
        chk("a_data", oa_dat, qa[0].dat);
        chk("a_sat", sa, qa[0].sat);
        if (!qa[0].seen && qa[0].lat) chk("a_latency", cyc - qa[0].acc, 2);
        qa[0].seen = 1'b1;
      end
    end
    chk("a_sat_count", ca, cnt_a);
    if (rst) begin
      qa.delete();
      cnt_a = 0;
    end else begin
      if (clr_a) cnt_a = 0;
      else if (oa_v && ora && qa.size() > 0 && (|qa[0].sat) && cnt_a != 65535) cnt_a++;
      if (oa_v && ora && qa.size() > 0) void'(qa.pop_front());
      if (va && ra) begin
        model({64'b0, da}, 16, 12, 32, 24, e.dat, e.sat);
        e.acc = cyc; e.lat = lat_on; e.seen = 1'b0;
        qa.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (on_v) begin
      if (qn.size() == 0) chk("n_spurious_valid", on_v, 0);
      else begin
        chk("n_data", {64'b0, odn}, qn[0].dat);
        chk("n_sat", sn, qn[0].sat);
        if (!qn[0].seen && qn[0].lat) chk("n_latency", cyc - qn[0].acc, 2);
        qn[0].seen = 1'b1;
      end
    end
    chk("n_sat_count", cn, cnt_n);
    if (rst) begin
      qn.delete();
      cnt_n = 0;
    end else begin
      if (clr_n) cnt_n = 0;
      else if (on_v && orn && qn.size() > 0 && (|qn[0].sat) && cnt_n != 3) cnt_n++;
      if (on_v && orn && qn.size() > 0) void'(qn.pop_front());
      if (vn && rn) begin
        model(dn, 32, 24, 16, 12, e.dat, e.sat);
        e.acc = cyc; e.lat = lat_on; e.seen = 1'b0;
        qn.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input bit nar, input logic [127:0] d);
    int n = 0;
    bit ok = 1'b0;
    if (nar) begin vn = 1'b1; dn = d; end
    else begin va = 1'b1; da = d[63:0]; end
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = nar ? rn : ra;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", ok, 1);
    if (nar) vn = 1'b0; else va = 1'b0;
  endtask

  localparam logic [127:0] SAT_BEAT = {64'b0, 32'hE0000000, 32'h10000000};

  initial begin
    rst = 1'b1; lat_on = 1'b1;
    va = 0; da = '0; ora = 1; clr_a = 0;
    vn = 0; dn = '0; orn = 1; clr_n = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_a_valid", oa_v, 0);
    chk("rst_a_data", oa_dat, 0);
    chk("rst_a_sat", sa, 0);
    chk("rst_a_count", ca, 0);
    chk("rst_a_in_ready", ra, 1);
    chk("rst_n_data", odn, 0);

    // widening, exact latency
    send(0, {64'b0, 16'h0000, 16'h7FFF, 16'h8000, 16'h1000});
    chk("wide_valid_at_1", oa_v, 0);
    @(posedge clk); #1;
    chk("wide_valid_at_2", oa_v, 1);
    chk("wide_data", oa_dat, {32'h00000000, 32'h07FFF000, 32'hF8000000, 32'h01000000});
    chk("wide_sat", sa, 0);

    send(0, {64'b0, 16'hC000, 16'h4000, 16'hFFFF, 16'h0001});
    @(posedge clk); #1;
    chk("wide_data2", oa_dat, {32'hFC000000, 32'h04000000, 32'hFFFFF000, 32'h00001000});
    send(0, {64'b0, 16'h8001, 16'h7FFF, 16'h0800, 16'hF001});
    repeat (3) @(posedge clk); #1;

    // narrowing, half-LSB rounding
    send(1, {64'b0, 32'hFFFFF800, 32'h00000800});
    @(posedge clk); #1;
`ifdef FXP_ROUND_EN
    chk("nar_round", odn[31:0], 32'h0000_0001);
`else
    chk("nar_round", odn[31:0], 32'hFFFF_0000);
`endif
    chk("nar_round_sat", sn, 0);

    // narrowing, saturation both directions
    send(1, SAT_BEAT);
    @(posedge clk); #1;
    chk("nar_sat_data", odn[31:0], 32'h8000_7FFF);
    chk("nar_sat_flags", sn, 4'b0011);
    @(posedge clk); #1;
    chk("nar_sat_count_1", cn, 1);

    send(1, {32'h07FFF000, 32'h7FFFFFFF, 32'hFFFFE800, 32'h00001800});
    repeat (3) @(posedge clk); #1;

    // counter: clear, then stick at all-ones
    clr_n = 1'b1;
    @(posedge clk); #1;
    clr_n = 1'b0;
    chk("cnt_cleared", cn, 0);
    for (int i = 0; i < 5; i++) send(1, SAT_BEAT);
    repeat (4) @(posedge clk); #1;
    chk("cnt_sticks", cn, 3);

    // clear wins over a same-cycle saturating accept
    send(1, SAT_BEAT);
    @(posedge clk); #1;
    chk("clr_pri_valid", on_v, 1);
    clr_n = 1'b1;
    @(posedge clk); #1;
    clr_n = 1'b0;
    chk("clr_priority", cn, 0);

    // backpressure: 4 beats, output stalled for 6 cycles
    lat_on = 1'b0;
    ora = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic [15:0] v;
          v = 16'((i + 1) * 256);
          send(0, {64'b0, {4{v}}});
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready_low", ra, 0);
        chk("bp_hold_beat0", oa_dat, {4{32'h00100000}});
        @(posedge clk);
        #1 ora = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("bp_drained", qa.size(), 0);
    lat_on = 1'b1;

    // reset with both stages holding saturating beats
    for (int i = 0; i < 3; i++) send(1, SAT_BEAT);
    chk("pre_rst_count", cn, 1);
    chk("pre_rst_valid", on_v, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", on_v, 0);
    chk("mid_rst_sat", sn, 0);
    chk("mid_rst_count", cn, 0);
    send(1, {64'b0, 32'hFFFFF800, 32'h00000800});
    chk("post_rst_valid_at_1", on_v, 0);
    @(posedge clk); #1;
    chk("post_rst_valid_at_2", on_v, 1);
`ifdef FXP_ROUND_EN
    chk("post_rst_data", odn[31:0], 32'h0000_0001);
`else
    chk("post_rst_data", odn[31:0], 32'hFFFF_0000);
`endif

    repeat (4) @(posedge clk); #1;
    chk("end_a_empty", qa.size(), 0);
    chk("end_n_empty", qn.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
